if_fetch: RTL

Instruction-fetch (IF) stage of the five-stage MIPS pipeline. It owns the PC, issues one instruction-SRAM read per cycle, and drives the IF→ID bus. It consumes the branch/jump redirect that the decode stage produces on `br_bus`. When the decode stage is stalled, it holds a stable instruction word for decode, because the SRAM read data would otherwise move on.

---
 rtl/if_fetch_pkg.sv | 26 ++
 rtl/if_inst_buf.sv | 42 ++++
 rtl/if_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, stall encoding and reset PC for the instruction-fetch stage.
// Replaces the old lib/defines.vh macros with typed package constants.
package if_fetch_pkg;

    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;
    localparam int StallBus    = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // First fetch lands on RESET_PC_VAL + 4 = 32'hBFC0_0000.
    localparam logic [31:0] RESET_PC_VAL = 32'hBFBF_FFFC;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

endpackage

// File: rtl/if_inst_buf.sv
// Instruction hold buffer: captures the SRAM word on the first stalled cycle
// and presents it to decode until the IF/ID stall releases.
module if_inst_buf
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic [31:0] rdata_in,
    output logic [31:0] inst_out
);

    logic        buf_v_q,    buf_v_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    // Only the first stalled cycle carries decode's word, so capture once.
    always_comb begin
        buf_v_d    = buf_v_q;
        buf_inst_d = buf_inst_q;
        if (hold == Stop) begin
            if (!buf_v_q) begin
                buf_v_d    = 1'b1;
                buf_inst_d = rdata_in;
            end
        end else begin
            buf_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_v_q    <= 1'b0;
            buf_inst_q <= 32'b0;
        end else begin
            buf_v_q    <= buf_v_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign inst_out = buf_v_q ? buf_inst_q : rdata_in;

endmodule

// File: rtl/if_fetch.sv
// MIPS IF stage: owns the PC, issues one SRAM read per cycle and remembers
// redirects that arrive while the PC is stalled. Define IF_INST_BUF_EN for the hold buffer.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VAL
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [StallBus-1:0]    stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [31:0]            inst_o
);

    br_bus_t     br;
    if_to_id_t   to_id;
    logic [31:0] pc_q,        pc_d;
    logic        ce_q,        ce_d;
    logic        pend_v_q,    pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    assign br = br_bus;

    // A fresh redirect beats a pending one; a newer redirect under stall replaces the old.
    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        if (stall[0] == NoStop) begin
            if (br.br_e)
                pc_d = br.br_addr;
            else if (pend_v_q)
                pc_d = pend_addr_q;
            else
                pc_d = pc_q + PC_STEP;
            ce_d     = 1'b1;
            pend_v_d = 1'b0;
        end else if (br.br_e) begin
            pend_v_d    = 1'b1;
            pend_addr_d = br.br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'b0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign to_id.ce        = ce_q;
    assign to_id.pc        = pc_q;
    assign if_to_id_bus    = to_id;
    assign inst_sram_en    = ce_q;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_wdata = 32'b0;

`ifdef IF_INST_BUF_EN
    logic unused_stall;
    assign unused_stall = ^stall[StallBus-1:2];

    if_inst_buf u_inst_buf (
        .clk      (clk),
        .rst      (rst),
        .hold     (stall[1]),
        .rdata_in (inst_sram_rdata),
        .inst_out (inst_o)
    );
`else
    // Without the buffer, stalls longer than one cycle rely on decode re-fetching.
    logic unused_stall;
    assign unused_stall = ^stall[StallBus-1:1];
    assign inst_o       = inst_sram_rdata;
`endif

endmodule
